// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C configuration sequencer: table op codes, FSM states,
// failure codes and the packed layout of one 26-bit table entry.
package i2c_cfg_pkg;

    localparam int ENTRY_W = 26;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_GAP,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DLY,
        S_NEXT,
        S_FIN,
        S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_NACK    = 2'b01,
        FC_VERIFY  = 2'b10,
        FC_TIMEOUT = 2'b11
    } fail_code_t;

    // Field order is the bit layout of TBL_DATA: op in [25:24], data in [7:0].
    typedef struct packed {
        op_t        op;
        logic [7:0] dev_id;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/i2c_cfg_if.sv
// User-side handshake between the config sequencer (master modport) and the
// I2C bus master it drives (slave modport).
interface i2c_cfg_if;
    logic       M_TRIG;
    logic       M_RNW;
    logic [7:0] M_WRCYC;
    logic [7:0] M_RDCYC;
    logic [7:0] M_DEVICE_ID;
    logic [7:0] M_REG_ADDR;
    logic [7:0] M_WDATA;
    logic       M_WVLD;
    logic       M_RVLD;
    logic [7:0] M_RDATA;
    logic       M_ERROR;
    logic       M_END;

    modport master (
        output M_TRIG, M_RNW, M_WRCYC, M_RDCYC, M_DEVICE_ID, M_REG_ADDR, M_WDATA,
        input  M_WVLD, M_RVLD, M_RDATA, M_ERROR, M_END
    );

    modport slave (
        input  M_TRIG, M_RNW, M_WRCYC, M_RDCYC, M_DEVICE_ID, M_REG_ADDR, M_WDATA,
        output M_WVLD, M_RVLD, M_RDATA, M_ERROR, M_END
    );
endinterface

// File: rtl/i2c_cfg_timer.sv
// Loadable down-counter with a zero flag; one instance serves the inter-transfer
// gap, the delay tick and the transfer timeout since they never overlap.
module i2c_cfg_timer #(
    parameter int W = 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Table-driven I2C configuration sequencer: per entry issues a write, read or delay to the I2C master.
// Build option: define I2C_CFG_VERIFY_EN to compare read bytes with the entry data (mismatch fails).
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int TBL_AW      = 5,
    parameter int RETRY_MAX   = 3,
    parameter int GAP_CYCLES  = 5000,
    parameter int DELAY_UNIT  = 50000,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic               FAIL,
    output logic [1:0]         FAIL_CODE,
    output logic [TBL_AW-1:0]  FAIL_IDX,
    output logic [TBL_AW-1:0]  TBL_ADDR,
    input  logic [ENTRY_W-1:0] TBL_DATA,
    i2c_cfg_if.master          m
);
    localparam int TMR_MAX_GD = (GAP_CYCLES > DELAY_UNIT) ? GAP_CYCLES : DELAY_UNIT;
    localparam int TMR_MAX    = (TIMEOUT_CYC > TMR_MAX_GD) ? TIMEOUT_CYC : TMR_MAX_GD;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int RW         = $clog2(RETRY_MAX + 2);

    state_t            state, state_next;
    entry_t            tbl_entry;
    logic              start_ok, tmr_load, tmr_zero, fail_set, verify_bad;
    logic [TMR_W-1:0]  tmr_value;
    fail_code_t        fail_code_next, fail_code;
    logic [TBL_AW-1:0] tbl_addr, fail_idx;
    logic [RW-1:0]     retries;
    logic [7:0]        ticks, rdata, dev_id, reg_addr, wdata;
    logic              rnw, err, fail;
    logic              unused_wvld;

    assign tbl_entry   = entry_t'(TBL_DATA);
    assign unused_wvld = m.M_WVLD;

`ifdef I2C_CFG_VERIFY_EN
    assign verify_bad = rnw && (rdata != wdata);
`else
    logic [7:0] unused_rdata;
    assign unused_rdata = rdata;
    assign verify_bad   = 1'b0;
`endif

    i2c_cfg_timer #(.W(TMR_W)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        start_ok       = 1'b0;
        tmr_load       = 1'b0;
        tmr_value      = '0;
        fail_set       = 1'b0;
        fail_code_next = FC_NONE;
        case (state)
            S_IDLE, S_FIN, S_FAIL: begin
                if (START) begin
                    state_next = S_FETCH;
                    start_ok   = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (tbl_entry.op)
                    OP_WRITE, OP_READ: begin
                        state_next = S_GAP;
                        tmr_load   = 1'b1;
                        tmr_value  = TMR_W'(GAP_CYCLES);
                    end
                    OP_DELAY: begin
                        if (tbl_entry.data == 8'd0) begin
                            state_next = S_NEXT;
                        end else begin
                            state_next = S_DLY;
                            tmr_load   = 1'b1;
                            tmr_value  = TMR_W'(DELAY_UNIT - 1);
                        end
                    end
                    default: state_next = S_FIN;
                endcase
            end
            S_GAP: if (tmr_zero) state_next = S_ISSUE;
            S_ISSUE: begin
                state_next = S_WAIT;
                tmr_load   = 1'b1;
                tmr_value  = TMR_W'(TIMEOUT_CYC);
            end
            S_WAIT: begin
                if (m.M_END) begin
                    state_next = S_CHECK;
                end else if (tmr_zero) begin
                    state_next     = S_FAIL;
                    fail_set       = 1'b1;
                    fail_code_next = FC_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (err) begin
                    if (retries < RW'(RETRY_MAX)) begin
                        state_next = S_GAP;
                        tmr_load   = 1'b1;
                        tmr_value  = TMR_W'(GAP_CYCLES);
                    end else begin
                        state_next     = S_FAIL;
                        fail_set       = 1'b1;
                        fail_code_next = FC_NACK;
                    end
                end else if (verify_bad) begin
                    state_next     = S_FAIL;
                    fail_set       = 1'b1;
                    fail_code_next = FC_VERIFY;
                end else begin
                    state_next = S_NEXT;
                end
            end
            // Each tick lasts DELAY_UNIT cycles; ticks counts the remaining ones.
            S_DLY: begin
                if (tmr_zero) begin
                    if (ticks == 8'd1) begin
                        state_next = S_NEXT;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(DELAY_UNIT - 1);
                    end
                end
            end
            S_NEXT: state_next = (&tbl_addr) ? S_FIN : S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tbl_addr  <= '0;
            fail_idx  <= '0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            retries   <= '0;
            ticks     <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            rnw       <= 1'b0;
            dev_id    <= '0;
            reg_addr  <= '0;
            wdata     <= '0;
        end else begin
            if (start_ok) begin
                tbl_addr  <= '0;
                retries   <= '0;
                fail      <= 1'b0;
                fail_code <= FC_NONE;
                fail_idx  <= '0;
            end
            if (state == S_DECODE) begin
                ticks <= tbl_entry.data;
                if (tbl_entry.op == OP_WRITE || tbl_entry.op == OP_READ) begin
                    rnw      <= (tbl_entry.op == OP_READ);
                    dev_id   <= tbl_entry.dev_id;
                    reg_addr <= tbl_entry.reg_addr;
                    wdata    <= tbl_entry.data;
                end
            end
            if (state == S_ISSUE) rdata <= '0;
            if (state == S_WAIT && rnw && m.M_RVLD) rdata <= m.M_RDATA;
            if (state == S_WAIT && m.M_END) err <= m.M_ERROR;
            if (state == S_CHECK && state_next == S_GAP) retries <= retries + RW'(1);
            if (state == S_DLY && tmr_zero) ticks <= ticks - 8'd1;
            if (state == S_NEXT) begin
                retries <= '0;
                if (!(&tbl_addr)) tbl_addr <= tbl_addr + TBL_AW'(1);
            end
            if (fail_set) begin
                fail      <= 1'b1;
                fail_code <= fail_code_next;
                fail_idx  <= tbl_addr;
            end
        end
    end

    assign BUSY          = (state != S_IDLE) && (state != S_FIN) && (state != S_FAIL);
    assign DONE          = (state == S_FIN) || (state == S_FAIL);
    assign FAIL          = fail;
    assign FAIL_CODE     = fail_code;
    assign FAIL_IDX      = fail_idx;
    assign TBL_ADDR      = tbl_addr;
    assign m.M_TRIG      = (state == S_ISSUE);
    assign m.M_RNW       = rnw;
    assign m.M_WRCYC     = 8'd1;
    assign m.M_RDCYC     = 8'd1;
    assign m.M_DEVICE_ID = dev_id;
    assign m.M_REG_ADDR  = reg_addr;
    assign m.M_WDATA     = wdata;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: table memory and I2C master model around the DUT,
// with expected transfers and completion status queued as a scoreboard.
module tb_i2c_cfg_sequencer;
    import i2c_cfg_pkg::*;

    localparam int TBL_AW    = 5;
    localparam int RETRY_MAX = 3;
    localparam int GAP       = 20;
    localparam int DUNIT     = 100;
    localparam int TMO       = 300;

    logic              CLK = 1'b0;
    logic              RST, START;
    logic              BUSY, DONE, FAIL;
    logic [1:0]        FAIL_CODE;
    logic [TBL_AW-1:0] FAIL_IDX, TBL_ADDR;
    logic [25:0]       TBL_DATA;

    i2c_cfg_if bus ();

    i2c_cfg_sequencer #(
        .TBL_AW(TBL_AW), .RETRY_MAX(RETRY_MAX), .GAP_CYCLES(GAP),
        .DELAY_UNIT(DUNIT), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .FAIL_CODE(FAIL_CODE), .FAIL_IDX(FAIL_IDX), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
        .m(bus)
    );

    always #5 CLK = ~CLK;

    logic [25:0] table_mem [32];
    logic [24:0] exp_trig [$];
    logic [7:0]  exp_done [$];
    int          pass_count = 0, check_count = 0;
    int          cycle = 0, trig_count = 0, done_count = 0;
    int          trig_cycle = 0, done_cycle = 0, last_end_cycle = 0;
    int          nack_reg = -1, nack_left = 0, delay_check_reg = -1;
    logic [7:0]  read_value = 8'h00;
    bit          no_end = 1'b0;

    always @(posedge CLK) cycle <= cycle + 1;
    always @(posedge CLK) TBL_DATA <= table_mem[TBL_ADDR];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic clearTable();
        for (int i = 0; i < 32; i++) table_mem[i] = {OP_END, 24'h0};
    endtask

    task automatic setEntry(input int idx, input op_t op, input logic [7:0] dev, input logic [7:0] rg,
                            input logic [7:0] data);
        table_mem[idx] = {op, dev, rg, data};
    endtask

    task automatic pushTrig(input logic rnw, input logic [7:0] dev, input logic [7:0] rg,
                            input logic [7:0] data, input int copies);
        for (int i = 0; i < copies; i++) exp_trig.push_back({rnw, dev, rg, data});
    endtask

    // Master model: answers each M_TRIG with an optional read byte and an M_END pulse.
    task automatic serveTransfer();
        logic [24:0] exp;
        logic        nack;
        trig_count++;
        trig_cycle = cycle;
        checkOutput("trig expected", 32'(exp_trig.size() != 0), 1);
        if (exp_trig.size() == 0) return;
        exp = exp_trig.pop_front();
        checkOutput("trig fields", 32'({bus.M_RNW, bus.M_DEVICE_ID, bus.M_REG_ADDR, bus.M_WDATA}), 32'(exp));
        if (int'(bus.M_REG_ADDR) == delay_check_reg)
            checkOutput("delay spacing", 32'((cycle - last_end_cycle >= 3 * DUNIT + GAP) &&
                                             (cycle - last_end_cycle <= 3 * DUNIT + GAP + 20)), 1);
        if (no_end) return;
        repeat (3) @(posedge CLK);
        #1;
        if (bus.M_RNW) begin
            bus.M_RVLD  = 1'b1;
            bus.M_RDATA = read_value;
        end
        @(posedge CLK);
        #1;
        bus.M_RVLD = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nack = (int'(bus.M_REG_ADDR) == nack_reg) && (nack_left > 0);
        if (nack) nack_left--;
        bus.M_ERROR = nack;
        bus.M_END   = 1'b1;
        checkOutput("fields stable", 32'({bus.M_DEVICE_ID, bus.M_REG_ADDR, bus.M_WDATA}), 32'(exp[23:0]));
        @(posedge CLK);
        #1;
        bus.M_END      = 1'b0;
        bus.M_ERROR    = 1'b0;
        last_end_cycle = cycle;
    endtask

    initial begin
        bus.M_END = 1'b0; bus.M_ERROR = 1'b0; bus.M_RVLD = 1'b0; bus.M_RDATA = 8'h00; bus.M_WVLD = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.M_TRIG === 1'b1) serveTransfer();
        end
    end

    initial begin
        logic [7:0] r;
        forever begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) begin
                done_count++;
                done_cycle = cycle;
                checkOutput("done expected", 32'(exp_done.size() != 0), 1);
                if (exp_done.size() != 0) begin
                    r = exp_done.pop_front();
                    checkOutput("done status", 32'({BUSY, FAIL, FAIL_CODE, FAIL_IDX}), 32'({1'b0, r}));
                end
            end
        end
    end

    // exp_result = {FAIL, FAIL_CODE, FAIL_IDX} expected at DONE.
    task automatic applyStimulus(input string name, input logic [7:0] exp_result, input int mid_start);
        int start_done, waited;
        exp_done.push_back(exp_result);
        start_done = done_count;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        checkOutput({name, " busy"}, 32'(BUSY), 1);
        checkOutput({name, " fail clr"}, 32'(FAIL), 0);
        waited = 0;
        while (done_count == start_done && waited < 5000) begin
            @(negedge CLK);
            waited++;
            if (waited == mid_start) begin
                START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
                waited++;
            end
        end
        checkOutput({name, " done seen"}, 32'(done_count != start_done), 1);
        checkOutput({name, " trigs left"}, 32'(exp_trig.size()), 0);
        if (done_count == start_done) begin
            exp_done.delete();
            exp_trig.delete();
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int t0, d0, waited;
        RST = 1'b1;
        START = 1'b0;
        clearTable();
        repeat (3) @(negedge CLK);
        checkOutput("rst status", 32'({BUSY, DONE, FAIL, FAIL_CODE, FAIL_IDX, TBL_ADDR}), 0);
        checkOutput("rst bus", 32'({bus.M_TRIG, bus.M_RNW, bus.M_DEVICE_ID, bus.M_REG_ADDR, bus.M_WDATA}), 0);
        checkOutput("rst cyc", 32'({bus.M_WRCYC, bus.M_RDCYC}), 'h0101);
        RST = 1'b0;
        @(negedge CLK);

        setEntry(0, OP_WRITE, 8'h98, 8'h10, 8'hA5);
        pushTrig(1'b0, 8'h98, 8'h10, 8'hA5, 1);
        applyStimulus("write", 8'h00, 0);

        clearTable();
        setEntry(0, OP_READ, 8'h98, 8'h20, 8'h3C);
        read_value = 8'h3C;
        pushTrig(1'b1, 8'h98, 8'h20, 8'h3C, 1);
        applyStimulus("read ok", 8'h00, 0);
        read_value = 8'h3D;
        pushTrig(1'b1, 8'h98, 8'h20, 8'h3C, 1);
`ifdef I2C_CFG_VERIFY_EN
        applyStimulus("read bad", {1'b1, 2'b10, 5'd0}, 0);
`else
        applyStimulus("read bad", 8'h00, 0);
`endif

        clearTable();
        for (int i = 0; i < 3; i++) setEntry(i, OP_WRITE, 8'h6A, 8'(i + 1), 8'(8'h40 + i));
        nack_reg  = 3;
        nack_left = 100;
        pushTrig(1'b0, 8'h6A, 8'h01, 8'h40, 1);
        pushTrig(1'b0, 8'h6A, 8'h02, 8'h41, 1);
        pushTrig(1'b0, 8'h6A, 8'h03, 8'h42, 1 + RETRY_MAX);
        applyStimulus("nack fail", {1'b1, 2'b01, 5'd2}, 0);
        nack_left = 1;
        pushTrig(1'b0, 8'h6A, 8'h01, 8'h40, 1);
        pushTrig(1'b0, 8'h6A, 8'h02, 8'h41, 1);
        pushTrig(1'b0, 8'h6A, 8'h03, 8'h42, 2);
        applyStimulus("nack retry", 8'h00, 0);
        nack_reg = -1;

        clearTable();
        setEntry(0, OP_WRITE, 8'h98, 8'h11, 8'h01);
        setEntry(1, OP_DELAY, 8'h00, 8'h00, 8'h03);
        setEntry(2, OP_WRITE, 8'h98, 8'h12, 8'h02);
        delay_check_reg = 'h12;
        pushTrig(1'b0, 8'h98, 8'h11, 8'h01, 1);
        pushTrig(1'b0, 8'h98, 8'h12, 8'h02, 1);
        applyStimulus("delay", 8'h00, 0);
        delay_check_reg = -1;

        clearTable();
        setEntry(0, OP_WRITE, 8'h98, 8'h21, 8'h44);
        no_end = 1'b1;
        pushTrig(1'b0, 8'h98, 8'h21, 8'h44, 1);
        applyStimulus("timeout", {1'b1, 2'b11, 5'd0}, 0);
        checkOutput("timeout length", 32'((done_cycle - trig_cycle >= TMO) &&
                                          (done_cycle - trig_cycle <= TMO + 5)), 1);
        no_end = 1'b0;
        pushTrig(1'b0, 8'h98, 8'h21, 8'h44, 1);
        applyStimulus("rerun", 8'h00, 0);

        clearTable();
        setEntry(0, OP_WRITE, 8'h98, 8'h31, 8'h77);
        pushTrig(1'b0, 8'h98, 8'h31, 8'h77, 1);
        no_end = 1'b1;
        t0 = trig_count;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        waited = 0;
        while (trig_count == t0 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("rst trig seen", 32'(trig_count != t0), 1);
        repeat (3) @(negedge CLK);
        d0 = done_count;
        RST = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        checkOutput("rst wait status", 32'({BUSY, DONE, FAIL, FAIL_CODE, TBL_ADDR}), 0);
        checkOutput("rst wait bus", 32'({bus.M_TRIG, bus.M_RNW, bus.M_DEVICE_ID, bus.M_REG_ADDR, bus.M_WDATA}), 0);
        RST = 1'b0;
        START = 1'b0;
        repeat (5) @(negedge CLK);
        checkOutput("rst start lost", 32'(BUSY), 0);
        checkOutput("rst no done", 32'(done_count), 32'(d0));
        no_end = 1'b0;

        for (int i = 0; i < 32; i++) begin
            setEntry(i, OP_WRITE, 8'h50, 8'(i), 8'(i ^ 8'h5A));
            pushTrig(1'b0, 8'h50, 8'(i), 8'(i ^ 8'h5A), 1);
        end
        applyStimulus("full table", 8'h00, 200);
        checkOutput("implicit end addr", 32'(TBL_ADDR), 31);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
